// File: rtl/axis_packet_generator.sv
// axis_packet_generator: framed AXI4-Stream traffic source with programmable length, count and gap.
// Define AXIS_PACKET_GENERATOR_LFSR_EN to build the 32-bit LFSR data mode (mode 2); otherwise mode 2 counts.
module axis_packet_generator #(
    parameter int AXIS_DATA_WIDTH = 32,
    parameter int LEN_WIDTH       = 16,
    parameter int GAP_WIDTH       = 8,
    parameter int NUM_WIDTH       = 16
) (
    input  logic                         clk_i,
    input  logic                         a_rst_n_i,
    input  logic                         enable_i,
    input  logic [LEN_WIDTH-1:0]         pkt_len_i,
    input  logic [GAP_WIDTH-1:0]         gap_i,
    input  logic [NUM_WIDTH-1:0]         pkt_num_i,
    input  logic [1:0]                   mode_i,
    input  logic [AXIS_DATA_WIDTH-1:0]   seed_i,
    output logic [AXIS_DATA_WIDTH-1:0]   m_axis_tdata_o,
    output logic [AXIS_DATA_WIDTH/8-1:0] m_axis_tkeep_o,
    output logic                         m_axis_tvalid_o,
    output logic                         m_axis_tlast_o,
    input  logic                         m_axis_tready_i,
    output logic                         busy_o,
    output logic                         done_o,
    output logic [NUM_WIDTH-1:0]         pkt_cnt_o
);
    localparam int BYTES = AXIS_DATA_WIDTH / 8;
    localparam int LOG2B = $clog2(BYTES);
    localparam logic [LEN_WIDTH-1:0]       LEN_ONE   = LEN_WIDTH'(1);
    localparam logic [LEN_WIDTH-1:0]       BYTE_MASK = LEN_WIDTH'(BYTES - 1);
    localparam logic [NUM_WIDTH-1:0]       NUM_ONE   = NUM_WIDTH'(1);
    localparam logic [GAP_WIDTH-1:0]       GAP_ONE   = GAP_WIDTH'(1);
    localparam logic [AXIS_DATA_WIDTH-1:0] DATA_ONE  = AXIS_DATA_WIDTH'(1);

    typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP, S_DONE} state_t;

    state_t                       r_state, w_state_nxt;
    logic [LEN_WIDTH-1:0]         r_beats_m1, r_beat, w_beat_nxt;
    logic [BYTES-1:0]             r_keep_last;
    logic [GAP_WIDTH-1:0]         r_gap, r_gap_cnt, w_gap_cnt_nxt;
    logic [NUM_WIDTH-1:0]         r_num, r_pkt_cnt, w_pkt_cnt_nxt, w_cnt_inc;
    logic [1:0]                   r_mode;
    logic [AXIS_DATA_WIDTH-1:0]   r_data, w_data_nxt, w_seed_data;
    logic [BYTES-1:0]             r_tkeep, w_tkeep_nxt;
    logic                         r_tvalid, w_tvalid_nxt, r_tlast, w_tlast_nxt;
    logic                         r_busy, r_done;

    logic [LEN_WIDTH-1:0]         w_len_m1, w_rem_m1, w_beats_m1_in, w_cur_beats_m1;
    logic [BYTES-1:0]             w_keep_in, w_cur_keep;
    logic                         w_accept, w_last, w_run_done, w_cfg_load, w_pkt_start;

    // Length 0 counts as 1; beats-1 = floor((len-1)/BYTES), final keep covers ((len-1) mod BYTES)+1 bytes.
    always_comb begin
        w_len_m1 = (pkt_len_i == '0) ? '0 : pkt_len_i - LEN_ONE;
        w_rem_m1 = w_len_m1 & BYTE_MASK;
        for (int b = 0; b < BYTES; b++)
            w_keep_in[b] = (LEN_WIDTH'(b) <= w_rem_m1);
    end
    assign w_beats_m1_in = w_len_m1 >> LOG2B;

    assign w_accept   = r_tvalid & m_axis_tready_i;
    assign w_last     = (r_beat == r_beats_m1);
    assign w_cnt_inc  = r_pkt_cnt + NUM_ONE;
    assign w_run_done = (r_num != '0) && (w_cnt_inc == r_num);
    assign w_cfg_load = (r_state == S_IDLE) && enable_i;

`ifdef AXIS_PACKET_GENERATOR_LFSR_EN
    logic [31:0] r_lfsr, w_lfsr_seed, w_lfsr_step;

    function automatic logic [AXIS_DATA_WIDTH-1:0] lfsr_rep(input logic [31:0] v);
        logic [AXIS_DATA_WIDTH-1:0] r;
        for (int i = 0; i < AXIS_DATA_WIDTH; i++) r[i] = v[i % 32];
        return r;
    endfunction

    always_comb begin
        w_lfsr_seed = '0;
        for (int i = 0; i < 32; i++)
            if (i < AXIS_DATA_WIDTH) w_lfsr_seed[i] = seed_i[i % AXIS_DATA_WIDTH];
        if (w_lfsr_seed == '0) w_lfsr_seed = 32'h1;
    end
    // Galois form of x^32+x^22+x^2+x+1
    assign w_lfsr_step = {1'b0, r_lfsr[31:1]} ^ (r_lfsr[0] ? 32'h8020_0003 : 32'h0);
    assign w_seed_data = (mode_i == 2'd2) ? lfsr_rep(w_lfsr_seed) : seed_i;

    always_ff @(posedge clk_i or negedge a_rst_n_i) begin
        if (!a_rst_n_i)                           r_lfsr <= 32'h1;
        else if (w_cfg_load)                      r_lfsr <= w_lfsr_seed;
        else if (w_accept && (r_mode == 2'd2))    r_lfsr <= w_lfsr_step;
    end
`else
    assign w_seed_data = seed_i;
`endif

    always_ff @(posedge clk_i or negedge a_rst_n_i) begin
        if (!a_rst_n_i) r_state <= S_IDLE;
        else            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (enable_i) w_state_nxt = S_SEND;
            S_SEND: if (w_accept && w_last) begin
                if (w_run_done)       w_state_nxt = S_DONE;
                else if (!enable_i)   w_state_nxt = S_IDLE;
                else if (r_gap == '0) w_state_nxt = S_SEND;
                else                  w_state_nxt = S_GAP;
            end
            S_GAP:  if (r_gap_cnt <= GAP_ONE) w_state_nxt = enable_i ? S_SEND : S_IDLE;
            S_DONE: if (!enable_i) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // A new packet starts on entry to SEND or on a back-to-back last-beat handshake.
    assign w_pkt_start    = (w_state_nxt == S_SEND) && ((r_state != S_SEND) || (w_accept && w_last));
    assign w_cur_beats_m1 = w_cfg_load ? w_beats_m1_in : r_beats_m1;
    assign w_cur_keep     = w_cfg_load ? w_keep_in : r_keep_last;

    always_comb begin
        w_data_nxt    = r_data;
        w_beat_nxt    = r_beat;
        w_gap_cnt_nxt = r_gap_cnt;
        w_pkt_cnt_nxt = r_pkt_cnt;
        w_tkeep_nxt   = r_tkeep;
        w_tlast_nxt   = r_tlast;
        w_tvalid_nxt  = r_tvalid;
        if (w_cfg_load) begin
            w_data_nxt    = w_seed_data;
            w_pkt_cnt_nxt = '0;
        end
        if (w_accept) begin
            case (r_mode)
                2'd1:    w_data_nxt = r_data;
`ifdef AXIS_PACKET_GENERATOR_LFSR_EN
                2'd2:    w_data_nxt = lfsr_rep(w_lfsr_step);
`endif
                default: w_data_nxt = r_data + DATA_ONE;
            endcase
            if (w_last) begin
                w_pkt_cnt_nxt = w_cnt_inc;
            end else begin
                w_beat_nxt  = r_beat + LEN_ONE;
                w_tlast_nxt = (w_beat_nxt == r_beats_m1);
                w_tkeep_nxt = w_tlast_nxt ? r_keep_last : '1;
            end
        end
        if (r_state == S_GAP) w_gap_cnt_nxt = r_gap_cnt - GAP_ONE;
        if ((r_state == S_SEND) && (w_state_nxt == S_GAP)) w_gap_cnt_nxt = r_gap;
        if (w_pkt_start) begin
            w_beat_nxt   = '0;
            w_tvalid_nxt = 1'b1;
            w_tlast_nxt  = (w_cur_beats_m1 == '0);
            w_tkeep_nxt  = w_tlast_nxt ? w_cur_keep : '1;
        end
        if (w_state_nxt != S_SEND) begin
            w_tvalid_nxt = 1'b0;
            w_tlast_nxt  = 1'b0;
            w_tkeep_nxt  = '0;
        end
        if (w_state_nxt == S_IDLE) w_data_nxt = '0;
    end

    always_ff @(posedge clk_i or negedge a_rst_n_i) begin
        if (!a_rst_n_i) begin
            r_beats_m1  <= '0;
            r_keep_last <= '0;
            r_gap       <= '0;
            r_num       <= '0;
            r_mode      <= '0;
            r_data      <= '0;
            r_beat      <= '0;
            r_gap_cnt   <= '0;
            r_pkt_cnt   <= '0;
            r_tkeep     <= '0;
            r_tlast     <= 1'b0;
            r_tvalid    <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            if (w_cfg_load) begin
                r_beats_m1  <= w_beats_m1_in;
                r_keep_last <= w_keep_in;
                r_gap       <= gap_i;
                r_num       <= pkt_num_i;
                r_mode      <= mode_i;
            end
            r_data    <= w_data_nxt;
            r_beat    <= w_beat_nxt;
            r_gap_cnt <= w_gap_cnt_nxt;
            r_pkt_cnt <= w_pkt_cnt_nxt;
            r_tkeep   <= w_tkeep_nxt;
            r_tlast   <= w_tlast_nxt;
            r_tvalid  <= w_tvalid_nxt;
            r_busy    <= (w_state_nxt != S_IDLE);
            r_done    <= (w_state_nxt == S_DONE);
        end
    end

    assign m_axis_tdata_o  = r_data;
    assign m_axis_tkeep_o  = r_tkeep;
    assign m_axis_tvalid_o = r_tvalid;
    assign m_axis_tlast_o  = r_tlast;
    assign busy_o          = r_busy;
    assign done_o          = r_done;
    assign pkt_cnt_o       = r_pkt_cnt;

endmodule
